// File: rtl/rtc12_counter_if.sv
// Host-side bundle of the 12-hour RTC: control/preset inputs and time/status outputs.
// master = host driving presets; slave = the counter itself.
interface rtc12_counter_if;
    logic       en;
    logic       load;
    logic [3:0] ld_h12;
    logic       ld_pm;
    logic [5:0] ld_m;
    logic [5:0] ld_s;
    logic [3:0] h12;
    logic       pm;
    logic [5:0] m;
    logic [5:0] s;
    logic       sec_tick;
    logic       ld_err;

    modport master (
        output en, load, ld_h12, ld_pm, ld_m, ld_s,
        input  h12, pm, m, s, sec_tick, ld_err
    );

    modport slave (
        input  en, load, ld_h12, ld_pm, ld_m, ld_s,
        output h12, pm, m, s, sec_tick, ld_err
    );
endinterface

// File: rtl/rtc12_counter.sv
// Free-running 12-hour clock (hh:mm:ss AM/PM) advanced once per TICKS_PER_SEC clk cycles,
// with a validated one-cycle preset strobe.
module rtc12_counter #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input logic            clk,
    input logic            rst,
    rtc12_counter_if.slave bus
);
    localparam int unsigned     PW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc;
    logic [3:0]    h12_q, h12_n;
    logic          pm_q, pm_n;
    logic [5:0]    m_q, m_n;
    logic [5:0]    s_q, s_n;
    logic          tick_q, err_q;
    logic          load_ok, wrap;

    always_comb begin
        load_ok = bus.load && (bus.ld_h12 >= 4'd1) && (bus.ld_h12 <= 4'd12)
                  && (bus.ld_m <= 6'd59) && (bus.ld_s <= 6'd59);
        // a legal load in the wrap cycle swallows that second
        wrap    = bus.en && !load_ok && (presc == LAST);

        h12_n = h12_q;
        pm_n  = pm_q;
        m_n   = m_q;
        s_n   = s_q;
        if (s_q == 6'd59) begin
            s_n = '0;
            if (m_q == 6'd59) begin
                m_n = '0;
                if (h12_q == 4'd11) begin
                    h12_n = 4'd12;
                    pm_n  = ~pm_q;
                end else if (h12_q == 4'd12) begin
                    h12_n = 4'd1;
                end else begin
                    h12_n = h12_q + 4'd1;
                end
            end else begin
                m_n = m_q + 6'd1;
            end
        end else begin
            s_n = s_q + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc  <= '0;
            h12_q  <= 4'd12;
            pm_q   <= 1'b0;
            m_q    <= '0;
            s_q    <= '0;
            tick_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            tick_q <= wrap;
            err_q  <= bus.load && !load_ok;
            if (load_ok) begin
                presc <= '0;
                h12_q <= bus.ld_h12;
                pm_q  <= bus.ld_pm;
                m_q   <= bus.ld_m;
                s_q   <= bus.ld_s;
            end else if (bus.en) begin
                if (wrap) begin
                    presc <= '0;
                    h12_q <= h12_n;
                    pm_q  <= pm_n;
                    m_q   <= m_n;
                    s_q   <= s_n;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    assign bus.h12      = h12_q;
    assign bus.pm       = pm_q;
    assign bus.m        = m_q;
    assign bus.s        = s_q;
    assign bus.sec_tick = tick_q;
    assign bus.ld_err   = err_q;
endmodule

// File: tb/tb_rtc12_counter.sv
// Bench for rtc12_counter: time kept as seconds-of-day in a reference model,
// directed boundary scenarios followed by a randomized run.
module tb_rtc12_counter;
    localparam int unsigned TPS = 4;
    localparam int unsigned DAY = 86400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    rtc12_counter_if bus ();

    rtc12_counter #(.TICKS_PER_SEC(TPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // reference model state
    int unsigned ref_sod  = 0;
    int unsigned ref_pc   = 0;
    int unsigned ref_tick = 0;
    int unsigned ref_err  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned to_sod(input int unsigned h, input int unsigned p,
                                           input int unsigned mm, input int unsigned ss);
        return ((h % 12) + (p != 0 ? 12 : 0)) * 3600 + mm * 60 + ss;
    endfunction

    task automatic check_all(input string tag);
        int unsigned hr24, eh;
        hr24 = ref_sod / 3600;
        eh   = (hr24 % 12 == 0) ? 12 : hr24 % 12;
        chk({tag, ".h12"}, 32'(bus.h12), eh);
        chk({tag, ".pm"},  32'(bus.pm), (hr24 >= 12) ? 1 : 0);
        chk({tag, ".m"},   32'(bus.m), (ref_sod / 60) % 60);
        chk({tag, ".s"},   32'(bus.s), ref_sod % 60);
        chk({tag, ".tick"}, 32'(bus.sec_tick), ref_tick);
        chk({tag, ".err"}, 32'(bus.ld_err), ref_err);
    endtask

    task automatic model_reset();
        ref_sod = 0; ref_pc = 0; ref_tick = 0; ref_err = 0;
    endtask

    // one clock edge: advance the model from the current inputs, then compare
    task automatic step(input string tag);
        bit legal;
        legal = bus.load && bus.ld_h12 >= 1 && bus.ld_h12 <= 12 && bus.ld_m <= 59 && bus.ld_s <= 59;
        ref_err  = (bus.load && !legal) ? 1 : 0;
        ref_tick = 0;
        if (legal) begin
            ref_sod = to_sod(bus.ld_h12, bus.ld_pm, bus.ld_m, bus.ld_s);
            ref_pc  = 0;
        end else if (bus.en) begin
            if (ref_pc == TPS - 1) begin
                ref_pc   = 0;
                ref_sod  = (ref_sod + 1) % DAY;
                ref_tick = 1;
            end else begin
                ref_pc++;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_ld(input int unsigned h, input int unsigned p,
                          input int unsigned mm, input int unsigned ss);
        bus.load   = 1'b1;
        bus.ld_h12 = 4'(h);
        bus.ld_pm  = p[0];
        bus.ld_m   = 6'(mm);
        bus.ld_s   = 6'(ss);
    endtask

    task automatic do_load(input string tag, input int unsigned h, input int unsigned p,
                           input int unsigned mm, input int unsigned ss);
        set_ld(h, p, mm, ss);
        step(tag);
        bus.load = 1'b0;
    endtask

    // called at posedge+1: assert rst between edges and check before the next edge
    task automatic async_rst(input string tag);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        rst = 1'b0;
        check_all({tag, "_hold"});
    endtask

    initial begin
        bus.en = 1'b0; bus.load = 1'b0;
        bus.ld_h12 = '0; bus.ld_pm = 1'b0; bus.ld_m = '0; bus.ld_s = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset");

        // 1: free run from reset
        bus.en = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step("t1");
            chk("t1_tick_const", 32'(bus.sec_tick), (c % 4 == 0) ? 1 : 0);
        end
        chk("t1_s_at_12", 32'(bus.s), 3);

        // 2: 11:59:59 PM rolls to 12:00:00 AM
        do_load("t2_ld", 11, 1, 59, 59);
        for (int c = 0; c < 4; c++) step("t2");
        chk("t2_h12", 32'(bus.h12), 12);
        chk("t2_pm", 32'(bus.pm), 0);
        chk("t2_m", 32'(bus.m), 0);
        chk("t2_s", 32'(bus.s), 0);
        chk("t2_tick", 32'(bus.sec_tick), 1);

        // 3: 12 -> 1 keeps meridiem; 11 AM -> 12 PM
        do_load("t3_ld", 12, 0, 59, 58);
        for (int c = 0; c < 8; c++) step("t3");
        chk("t3_h12", 32'(bus.h12), 1);
        chk("t3_pm", 32'(bus.pm), 0);
        do_load("t3_ld2", 11, 0, 59, 59);
        for (int c = 0; c < 4; c++) step("t3b");
        chk("t3b_h12", 32'(bus.h12), 12);
        chk("t3b_pm", 32'(bus.pm), 1);

        // 4: illegal presets rejected while counting continues
        do_load("t4_h0", 0, 0, 10, 10);
        chk("t4_err_h0", 32'(bus.ld_err), 1);
        do_load("t4_h13", 13, 1, 10, 10);
        do_load("t4_m60", 5, 0, 60, 10);
        do_load("t4_s63", 5, 0, 10, 63);
        step("t4_after");
        chk("t4_err_clear", 32'(bus.ld_err), 0);

        // 5: legal load lands in the prescaler-wrap cycle
        do_load("t5_sync", 3, 1, 20, 30);
        for (int c = 0; c < 3; c++) step("t5_pre");
        do_load("t5_wrap", 7, 0, 0, 0);
        chk("t5_no_tick", 32'(bus.sec_tick), 0);
        for (int c = 1; c <= 4; c++) begin
            step("t5_post");
            chk("t5_tick_const", 32'(bus.sec_tick), (c == 4) ? 1 : 0);
        end
        bus.en = 1'b0;
        for (int c = 0; c < 10; c++) step("t5_frozen");
        do_load("t5_ld_frozen", 9, 1, 45, 15);
        for (int c = 0; c < 6; c++) step("t5_frozen2");
        chk("t5_frozen_s", 32'(bus.s), 15);
        bus.en = 1'b1;

        // 6: async reset mid-count and during a load
        for (int c = 0; c < 6; c++) step("t6_run");
        async_rst("t6_rst_count");
        for (int c = 0; c < 5; c++) step("t6_run2");
        set_ld(4, 1, 30, 30);
        async_rst("t6_rst_load");
        for (int c = 0; c < 5; c++) step("t6_run3");

        // randomized run with range checks
        for (int c = 0; c < 20000; c++) begin
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 1) != 0)
                    set_ld($urandom_range(11, 12), $urandom_range(0, 1),
                           $urandom_range(58, 59), $urandom_range(56, 59));
                else
                    set_ld($urandom_range(0, 15), $urandom_range(0, 1),
                           $urandom_range(0, 63), $urandom_range(0, 63));
            end else begin
                bus.load = 1'b0;
            end
            step("rnd");
            chk("rnd_h12_range", 32'(bus.h12 >= 4'd1 && bus.h12 <= 4'd12), 1);
            chk("rnd_m_range", 32'(bus.m <= 6'd59), 1);
            chk("rnd_s_range", 32'(bus.s <= 6'd59), 1);
        end
        bus.load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
